tv_recorder: RTL
================

# tv_recorder

Test-vector recorder: captures a stream of WIDTH-bit vectors (packed DUT inputs plus observed outputs, e.g. {a,b,cin,cout,s}) into on-chip storage, then plays them back in order over a valid/ready stream with a last marker. It is the writer side of the vector flow: it builds the vector sets that a checker later consumes, directly from board switches and a DUT on the DE10-Lite. It sits between the capture source (switch debouncer plus DUT outputs) and any playback consumer (self-checker, UART dumper).

## Interface
- WIDTH, 5, bits per vector
- DEPTH, 16, vector storage entries (≥2); CW = $clog2(DEPTH+1)
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low; clears state, not memory contents
- arm  in  1  level, sampled each edge; starts a fresh recording
- stop  in  1  level, sampled each edge; ends recording or aborts playback
- play  in  1  level, sampled each edge; starts playback
- cap_valid  in  1  capture source has a vector
- cap_data  in  WIDTH  vector to record
- cap_ready  out  1  recorder accepts a vector this cycle
- out_valid  out  1  playback vector present
- out_data  out  WIDTH  playback vector
- out_last  out  1  out_data is the final stored vector
- out_ready  in  1  consumer accepts the playback vector
- count  out  CW  number of vectors stored (0..DEPTH)
- full  out  1  count == DEPTH
- busy  out  1  state is RECORD or PLAY

## Operation
- States: IDLE, RECORD, HOLD, PLAY. Reset (reset==0 at an edge) → IDLE, wr_ptr=0, rd_ptr=0, count=0. All outputs are 0 during reset and in the cycle after it.
- IDLE: cap_ready=0, out_valid=0. arm=1 → RECORD with count=0. play and stop are ignored.
- RECORD: cap_ready = (count < DEPTH). A capture is a cycle with cap_valid & cap_ready. It writes mem[wr_ptr] ← cap_data, increments wr_ptr and count.
  - stop=1 → HOLD. A capture in the same cycle is still stored.
  - A capture that makes count reach DEPTH → HOLD automatically on that edge.
  - arm is ignored while in RECORD.
- HOLD: cap_ready=0, out_valid=0, stored data is retained.
  - arm=1 → RECORD, count and wr_ptr cleared. arm has priority over play.
  - play=1 with count>0 → PLAY, rd_ptr=0.
  - play with count==0 is ignored; the block stays in HOLD.
- PLAY: out_valid=1, out_data = mem[rd_ptr] (combinational read of a registered pointer), out_last = (rd_ptr == count-1).
  - A handshake is a cycle with out_valid & out_ready. It increments rd_ptr.
  - A handshake with out_last=1 → HOLD.
  - stop=1 → HOLD (abort). A handshake in the same cycle is counted, but playback still ends.
  - arm and play are ignored in PLAY.
  - Playback may be repeated from HOLD any number of times.
- Data must not change while out_valid=1 and out_ready=0.
- Arithmetic: wr_ptr and rd_ptr are $clog2(DEPTH) bits and never wrap. count is CW bits, saturates at DEPTH, and is never decremented by playback.
- full and busy are decoded from registered state and count.

## Timing
- Capture latency: a vector accepted at edge N is readable from edge N+1. count updates at edge N.
- cap_ready drops in the cycle after the DEPTH-th capture.
- play sampled at edge N: out_valid=1 and out_data=mem[0] from N+1.
- Throughput: one vector per cycle in both directions when valid and ready are held high.
- After the last handshake at edge N: out_valid=0 from N+1 and state=HOLD.
- stop or reset mid-operation takes effect at the same edge. Outputs are deasserted from the next cycle.

## Test plan
- Reset then record: arm, present 5'b00000, 5'b00101, 5'b01001, 5'b11111 with cap_valid held, then stop → count=4, full=0, state HOLD, busy=0.
- Playback with back-pressure: play with out_ready toggling 1,0,1,0…. Required response:
  - the same 4 vectors appear in order;
  - out_data is stable while out_ready=0;
  - out_last=1 only on 5'b11111;
  - out_valid=0 the cycle after the final handshake.
- Fill to capacity: DEPTH=16, arm, 20 consecutive valid vectors 0..19 → exactly 0..15 stored, count=16, full=1, cap_ready=0 from cycle 17, auto-HOLD, playback ends on 15 with out_last.
- Simultaneous events: capture with stop in the same cycle → vector stored. arm with play in HOLD → RECORD with count=0. play with count==0 → stays HOLD, out_valid stays 0.
- Abort and re-arm: stop after 2 of 4 playback handshakes → HOLD, count stays 4. A second play restarts from mem[0].
- Reset mid-RECORD after 3 captures (reset=0 for one edge) → IDLE, count=0, all outputs 0. A subsequent play is ignored until a new arm.

Source files
------------

// File: rtl/tv_recorder.sv
// Test-vector recorder: captures a stream of WIDTH-bit vectors into local storage,
// then replays them in order over a valid/ready stream with a last marker.
module tv_recorder #(
   parameter int unsigned WIDTH = 5,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             arm_i,
   input  logic             stop_i,
   input  logic             play_i,
   input  logic             cap_valid_i,
   input  logic [WIDTH-1:0] cap_data_i,
   output logic             cap_ready_o,
   output logic             out_valid_o,
   output logic [WIDTH-1:0] out_data_o,
   output logic             out_last_o,
   input  logic             out_ready_i,
   output logic [CW-1:0]    count_o,
   output logic             full_o,
   output logic             busy_o
);

   // state  | meaning
   // IDLE   | after reset, nothing recorded, waiting for arm
   // RECORD | accepting capture vectors until stop or storage full
   // HOLD   | recording retained, waiting for play or a new arm
   // PLAY   | streaming stored vectors out from entry 0
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RECORD = 2'd1,
      S_HOLD   = 2'd2,
      S_PLAY   = 2'd3
   } state_t;

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);
   localparam logic [PW-1:0] PMAX_C  = PW'(DEPTH - 1);

   state_t           state_q;
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic cap_ready;
   logic cap_fire;
   logic out_valid;
   logic out_last;
   logic out_fire;

   assign cap_ready = (state_q == S_RECORD) && (count_q < DEPTH_C);
   assign cap_fire  = cap_valid_i && cap_ready;
   assign out_valid = (state_q == S_PLAY);
   assign out_last  = out_valid && (CW'(rd_ptr_q) == count_q - CW'(1));
   assign out_fire  = out_valid && out_ready_i;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (arm_i) begin
                  state_q  <= S_RECORD;
                  wr_ptr_q <= '0;
                  count_q  <= '0;
               end
            end
            S_RECORD: begin
               if (cap_fire) begin
                  count_q <= count_q + CW'(1);
                  // pointer stays on the last entry rather than wrapping
                  if (wr_ptr_q != PMAX_C) wr_ptr_q <= wr_ptr_q + PW'(1);
               end
               if (stop_i || (cap_fire && count_q == LAST_C)) state_q <= S_HOLD;
            end
            S_HOLD: begin
               if (arm_i) begin
                  state_q  <= S_RECORD;
                  wr_ptr_q <= '0;
                  count_q  <= '0;
               end else if (play_i && count_q != '0) begin
                  state_q  <= S_PLAY;
                  rd_ptr_q <= '0;
               end
            end
            S_PLAY: begin
               if (out_fire && !out_last) rd_ptr_q <= rd_ptr_q + PW'(1);
               if (stop_i || (out_fire && out_last)) state_q <= S_HOLD;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // storage is deliberately not reset so a recording survives a state reset
   always_ff @(posedge clk) begin
      if (reset && cap_fire) mem_q[wr_ptr_q] <= cap_data_i;
   end

   assign cap_ready_o = cap_ready;
   assign out_valid_o = out_valid;
   assign out_data_o  = out_valid ? mem_q[rd_ptr_q] : '0;
   assign out_last_o  = out_last;
   assign count_o     = count_q;
   assign full_o      = (count_q == DEPTH_C);
   assign busy_o      = (state_q == S_RECORD) || (state_q == S_PLAY);

endmodule
